// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: rotating-pointer search with per-requester
// burst credit, registered one-hot grant, and back-pressure freeze.
module weighted_rr_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQUESTERS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ready,
  input  logic [NUM_REQUESTERS-1:0]              requesters,
  input  logic [NUM_REQUESTERS*WEIGHT_WIDTH-1:0] weights,
  output logic [NUM_REQUESTERS-1:0]              valid,
  output logic [ID_WIDTH-1:0]                    grant_id,
  output logic [WEIGHT_WIDTH-1:0]                credit
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                      state_r, state_s;
  logic [ID_WIDTH-1:0]         ptr_r, ptr_s, arb_ptr_s, ptr_inc_s;
  logic [NUM_REQUESTERS-1:0]   valid_s;
  logic [ID_WIDTH-1:0]         id_s;
  logic [WEIGHT_WIDTH-1:0]     credit_s;
  logic                        rearb_s;
  logic [ID_WIDTH:0]           win_s;

  // Returns {found, index}; descending scan so the smallest offset from ptr wins.
  function automatic logic [ID_WIDTH:0] pick_winner(
    input logic [NUM_REQUESTERS-1:0] req,
    input logic [ID_WIDTH-1:0]       ptr
  );
    logic [ID_WIDTH:0] result;
    int                idx;
    result = {(ID_WIDTH+1){1'b0}};
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
      else                       idx = idx;
      if (req[ID_WIDTH'(idx)]) result = {1'b1, ID_WIDTH'(idx)};
      else                     result = result;
    end
    return result;
  endfunction

  // A programmed weight of zero still grants one transfer.
  function automatic logic [WEIGHT_WIDTH-1:0] load_credit(
    input logic [ID_WIDTH-1:0]                    id,
    input logic [NUM_REQUESTERS*WEIGHT_WIDTH-1:0] w
  );
    logic [WEIGHT_WIDTH-1:0] v;
    v = w[int'(id)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    if (v == {WEIGHT_WIDTH{1'b0}}) return WEIGHT_WIDTH'(1'b1);
    else                           return v;
  endfunction

  function automatic logic [NUM_REQUESTERS-1:0] onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_REQUESTERS-1:0] oh;
    oh = {NUM_REQUESTERS{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Pointer successor of the current grant, wrapping at the last requester.
  always_comb begin
    if (grant_id == ID_WIDTH'(NUM_REQUESTERS - 1)) ptr_inc_s = {ID_WIDTH{1'b0}};
    else                                           ptr_inc_s = grant_id + ID_WIDTH'(1'b1);
  end

  // Next-state, pointer and grant outputs.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    valid_s   = valid;
    id_s      = grant_id;
    credit_s  = credit;
    rearb_s   = 1'b0;
    arb_ptr_s = ptr_r;
    case (state_r)
      ST_IDLE: begin
        rearb_s   = 1'b1;
        arb_ptr_s = ptr_r;
      end
      ST_GRANT: begin
        if (!requesters[grant_id] || (ready && credit == WEIGHT_WIDTH'(1'b1))) begin
          rearb_s   = 1'b1;
          arb_ptr_s = ptr_inc_s;
          ptr_s     = ptr_inc_s;
        end else if (ready) begin
          credit_s = credit - WEIGHT_WIDTH'(1'b1);
        end else begin
          credit_s = credit;
        end
      end
      default: begin
        rearb_s   = 1'b1;
        arb_ptr_s = ptr_r;
      end
    endcase

    win_s = pick_winner(requesters, arb_ptr_s);
    if (rearb_s) begin
      if (win_s[ID_WIDTH]) begin
        state_s  = ST_GRANT;
        id_s     = win_s[ID_WIDTH-1:0];
        valid_s  = onehot(win_s[ID_WIDTH-1:0]);
        credit_s = load_credit(win_s[ID_WIDTH-1:0], weights);
      end else begin
        state_s  = ST_IDLE;
        id_s     = {ID_WIDTH{1'b0}};
        valid_s  = {NUM_REQUESTERS{1'b0}};
        credit_s = {WEIGHT_WIDTH{1'b0}};
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {ID_WIDTH{1'b0}};
      valid    <= {NUM_REQUESTERS{1'b0}};
      grant_id <= {ID_WIDTH{1'b0}};
      credit   <= {WEIGHT_WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      valid    <= valid_s;
      grant_id <= id_s;
      credit   <= credit_s;
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed and randomized bench for weighted_rr_arbiter against a
// tenure-level reference model.
module tb_weighted_rr_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic [N-1:0] requesters;
  logic [N*W-1:0] weights;
  logic [N-1:0] valid;
  logic [1:0]   grant_id;
  logic [W-1:0] credit;

  int w [N];
  int checks = 0;
  int failures = 0;

  // model: who holds the resource, how many transfers remain, where search starts
  int m_busy, m_g, m_cred, m_ptr;

  weighted_rr_arbiter #(.NUM_REQUESTERS(N), .WEIGHT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .requesters(requesters),
    .weights(weights), .valid(valid), .grant_id(grant_id), .credit(credit)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) weights[i*W +: W] = w[i][W-1:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_arb(input int p);
    m_busy = 0; m_g = 0; m_cred = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (requesters[i]) begin
        m_busy = 1; m_g = i; m_cred = (w[i] == 0) ? 1 : w[i];
        break;
      end
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_g = 0; m_cred = 0; m_ptr = 0;
    end else if (m_busy == 0) begin
      model_arb(m_ptr);
    end else if (!requesters[m_g] || (ready && m_cred == 1)) begin
      m_ptr = (m_g + 1) % N;
      model_arb(m_ptr);
    end else if (ready) begin
      m_cred = m_cred - 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", 32'(valid), m_busy ? (32'd1 << m_g) : 32'd0);
    chk("model_grant_id", 32'(grant_id), 32'(m_g));
    chk("model_credit", 32'(credit), 32'(m_cred));
  endtask

  initial begin
    int rot_exp [8];
    rot_exp = '{1, 2, 2, 4, 4, 4, 8, 1};
    m_busy = 0; m_g = 0; m_cred = 0; m_ptr = 0;
    w = '{1, 2, 3, 1};
    rst = 1'b1; ready = 1'b0; requesters = 4'b0000;

    // reset and idle
    step(); step();
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_credit", 32'(credit), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("idle_valid", 32'(valid), 32'd0);

    // weighted rotation
    requesters = 4'b1111; ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      chk("rotation_valid", 32'(valid), 32'(rot_exp[s]));
    end

    // back-pressure on requester 1 with weight 3
    w[1] = 3; w[2] = 4;
    step();
    chk("bp_load_valid", 32'(valid), 32'd2);
    chk("bp_load_credit", 32'(credit), 32'd3);
    ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("bp_freeze_credit", 32'(credit), 32'd3);
    end
    ready = 1'b1;
    step(); chk("bp_credit2", 32'(credit), 32'd2);
    step(); chk("bp_credit1", 32'(credit), 32'd1);
    step();
    chk("bp_next_valid", 32'(valid), 32'd4);
    chk("early_load_credit", 32'(credit), 32'd4);

    // early drop after one transfer
    step(); chk("early_credit3", 32'(credit), 32'd3);
    requesters = 4'b1000;
    step();
    chk("early_drop_valid", 32'(valid), 32'd8);
    chk("early_drop_id", 32'(grant_id), 32'd3);
    requesters = 4'b0000;
    step();
    chk("drop_to_idle", 32'(valid), 32'd0);

    // sole requester, zero weight
    w[2] = 0; requesters = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      step();
      chk("sole_valid", 32'(valid), 32'd4);
      chk("sole_credit", 32'(credit), 32'd1);
    end

    // mid-burst reset then wrap
    w[3] = 2; requesters = 4'b1000; ready = 1'b0;
    step();
    chk("mid_valid", 32'(valid), 32'd8);
    chk("mid_credit", 32'(credit), 32'd2);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_credit", 32'(credit), 32'd0);
    rst = 1'b0; requesters = 4'b1001; ready = 1'b1; w[0] = 1;
    step(); chk("wrap_first", 32'(valid), 32'd1);
    step(); chk("wrap_second", 32'(valid), 32'd8);
    step(); chk("wrap_second_hold", 32'(valid), 32'd8);
    step(); chk("wrap_back", 32'(valid), 32'd1);

    // randomized traffic against the model
    for (int s = 0; s < 3000; s++) begin
      rst = ($urandom_range(0, 99) == 0);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) requesters = 4'($urandom);
      else if ($urandom_range(0, 7) == 0) requesters = 4'($urandom) & 4'($urandom);
      else requesters = requesters;
      if ($urandom_range(0, 7) == 0) w[$urandom_range(0, N-1)] = $urandom_range(0, 15);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Parametrised successor to the team's single-grant round-robin arbiter. Arbitrates NUM_REQUESTERS requesters onto one shared resource using a rotating priority pointer. Each requester carries a programmable weight, granting it up to that many ready-qualified transfers per tenure. Downstream back-pressure (ready low) freezes the current burst. Sits between request sources and a shared bus/port; the grant is registered.

Parameters:
NUM_REQUESTERS, 4, number of requesters (>=2)
WEIGHT_WIDTH, 4, bits per requester weight
ID_WIDTH, $clog2(NUM_REQUESTERS), width of grant_id (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ready  input  1  downstream accepts a transfer this cycle
requesters  input  NUM_REQUESTERS  request vector, bit i = requester i
weights  input  NUM_REQUESTERS*WEIGHT_WIDTH  weight i in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
valid  output  NUM_REQUESTERS  one-hot registered grant, all zero when idle
grant_id  output  ID_WIDTH  binary index of granted requester, 0 when idle
credit  output  WEIGHT_WIDTH  remaining transfers in current tenure, 0 when idle

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst). On a rst edge: valid=0, grant_id=0, credit=0, pointer=0, state IDLE. Overrides everything, including mid-burst; the in-flight burst is dropped without completion.
- State machine: IDLE, GRANT.
- Arbitration function: search requesters starting at index pointer, ascending with wrap; first set bit wins. Pure combinational, used in IDLE and on release.
- IDLE: if requesters != 0 at an edge, go to GRANT. Set valid=onehot(winner), grant_id=winner, credit=weights[winner]. A weight of 0 loads as 1. Latency: request sampled at edge k, grant visible after edge k (one cycle, registered). If requesters == 0, stay IDLE with outputs zero.
- GRANT, per edge, with g = grant_id:
  - requesters[g]==0: release immediately regardless of ready or credit.
  - ready==1 and credit==1: last transfer; release.
  - ready==1 and credit>1: credit decrements, grant held.
  - ready==0: hold grant and credit unchanged (burst freeze). No timeout.
- Release: pointer = (g+1) mod NUM_REQUESTERS, wrapping from NUM_REQUESTERS-1 to 0. In the same edge, re-arbitrate with the new pointer against current requesters, with no idle bubble.
  - If a winner exists: new grant, credit reloaded from its weight. If g is the only requester, it is re-granted with fresh credit.
  - If no winner: go to IDLE, outputs zero.
- Weights are sampled only at grant load; changes mid-tenure take effect at the next tenure.
- Requesters rising during a tenure cannot preempt it.
- valid is always one-hot or zero; grant_id and credit are consistent with valid every cycle.
- A transfer occurs on any cycle with valid[g]=1, ready=1 and requesters[g]=1.
- Fairness: each requester continuously requesting gets a tenure within NUM_REQUESTERS-1 other tenures.

Test Plan:
- Reset/idle: rst=1 for 2 edges, requesters=0 -> valid=0, grant_id=0, credit=0; hold after rst drops.
- Weighted rotation: weights={1,3,2,1} (req3..req0), requesters=4'b1111, ready=1 -> valid sequence 0001, 0010, 0010, 0100, 0100, 0100, 1000, 0001; no gaps.
- Back-pressure: requester 1 granted with weight 3, credit=3; ready=0 for 4 cycles -> valid=0010, credit=3 held. Ready=1 -> credit 2, 1, then grant moves to the next requester.
- Early drop: requester 2 granted credit=4, drops request after 1 transfer -> next edge grant moves to requester 3 (if requesting) or IDLE; pointer=3.
- Sole requester and zero weight: requesters=4'b0100, weights[2]=0, ready=1 -> valid=0100 every cycle, credit=1 each cycle (re-granted, weight 0 treated as 1).
- Mid-burst reset and wrap: requester 3 granted credit=2, assert rst -> outputs zero next edge. Release rst with requesters=4'b1001 -> requester 0 granted first (pointer=0). After its release, requester 3 is granted, then wraps back to 0.
